// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared definitions for the instruction fetch unit and the
//               instruction memory it talks to: default geometry of the
//               instruction space, fetch FSM state encoding, and a small
//               address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    // Default instruction-space geometry, shared with the instruction memory.
    localparam int DEF_INS_SIZE    = 32;   // instruction word width
    localparam int DEF_INS_LENGTH  = 256;  // number of valid instruction addresses
    localparam int DEF_COUNTSIZE   = 8;    // program counter / address width
    localparam int DEF_BUF_DEPTH   = 2;    // fetch FIFO entries
    localparam int DEF_LOOP_WINDOW = 3;    // issued addresses kept for loop check

    // Fetch FSM state encoding.
    typedef enum logic [1:0] {
        S_INIT    = 2'd0,  // waiting for the memory to come up
        S_SETTLE  = 2'd1,  // address held one cycle so memory can respond
        S_CAPTURE = 2'd2,  // sample returned word when memory reports done
        S_HALT    = 2'd3   // terminal until reset
    } fetch_state_e;

    // True when a (zero-extended) address lies inside the instruction space.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned len);
        return (addr < len);
    endfunction

endpackage : instruction_fetch_unit_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO between fetch and decode. The head
//               entry is kept in a dedicated register so the output is a
//               registered value that holds while the FIFO is empty.
//               Push and pop in the same cycle are legal when full.
//               Flush empties the FIFO and discards any same-cycle push/pop.
// Ports       : clk_i    - clock, rising edge
//               rst_ni   - asynchronous active-low reset
//               push_i   - write data_i (ignored when full without a pop)
//               pop_i    - remove head entry (ignored when empty)
//               flush_i  - drop all entries
//               data_i   - entry to write
//               data_o   - registered head entry
//               full_o   - all DEPTH entries occupied
//               empty_o  - no entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2     // power of two, >= 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] head_q,   head_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A flush wins over everything else in the same cycle.
    assign do_pop  = pop_i  && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            // Refresh the head register whenever something remains. If the
            // slot that becomes the head is being written this cycle, the
            // incoming word is forwarded; otherwise the stored word is used.
            if (count_d != '0) begin
                if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                    head_d = data_i;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o = head_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Initiator side of the instruction-memory interface. Owns the
//               program counter, presents it to the instruction memory,
//               captures the returned word once the memory reports done and
//               queues {PC, word} in a small FIFO for the decode stage.
//               Handles branch redirects and halts on a tight loop (branch
//               back into a recently issued address) or on running off the
//               end of the instruction space.
// Ports       : clk                   - clock, rising edge
//               reset                 - asynchronous active-low reset
//               currentCount          - fetch address to instruction memory
//               currentInstruction    - word returned by memory
//               instructionmemoryDone - memory data valid for currentCount
//               branchValid           - one-cycle redirect request
//               branchTarget          - redirect address
//               decodeReady           - decode accepts the FIFO head
//               fetchedInstruction    - FIFO head instruction
//               fetchedPC             - address of FIFO head instruction
//               fetchValid            - FIFO non-empty
//               loopDetected          - sticky tight-loop flag
//               rangeError            - sticky out-of-range flag
//               halted                - fetching stopped
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int INS_SIZE    = DEF_INS_SIZE,
    parameter int INS_LENGTH  = DEF_INS_LENGTH,
    parameter int COUNTSIZE   = DEF_COUNTSIZE,
    parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
    parameter int LOOP_WINDOW = DEF_LOOP_WINDOW
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [COUNTSIZE-1:0] currentCount,
    input  logic [INS_SIZE-1:0]  currentInstruction,
    input  logic                 instructionmemoryDone,
    input  logic                 branchValid,
    input  logic [COUNTSIZE-1:0] branchTarget,
    input  logic                 decodeReady,
    output logic [INS_SIZE-1:0]  fetchedInstruction,
    output logic [COUNTSIZE-1:0] fetchedPC,
    output logic                 fetchValid,
    output logic                 loopDetected,
    output logic                 rangeError,
    output logic                 halted
);

    localparam int                   ENTRY_W   = INS_SIZE + COUNTSIZE;
    localparam logic [COUNTSIZE-1:0] LAST_ADDR = COUNTSIZE'(INS_LENGTH - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fetch_state_e         state_q;
    logic [COUNTSIZE-1:0] pc_q;
    logic                 loop_q;
    logic                 range_q;
    logic                 halted_q;
    logic [COUNTSIZE-1:0] hist_q [LOOP_WINDOW];
    logic [LOOP_WINDOW-1:0] hist_v_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_head;
    logic                   pop;
    logic                   push;
    logic                   flush;
    logic                   branch_take;
    logic                   target_oob;
    logic [LOOP_WINDOW-1:0] hist_match;
    logic                   hist_hit;
    logic                   capture;
    logic                   at_last;
    logic [COUNTSIZE-1:0]   next_seq;
    logic                   branch_issue;
    logic                   seq_issue;
    logic                   issue;
    logic [COUNTSIZE-1:0]   issue_addr;

    assign pop = fetchValid && decodeReady;

    // Redirects are honoured only while actively fetching; in S_INIT the
    // memory is not yet ready and S_HALT is terminal.
    assign branch_take = branchValid &&
                         ((state_q == S_SETTLE) || (state_q == S_CAPTURE));
    assign target_oob  = !addr_in_range(32'(branchTarget), INS_LENGTH);

    // Compare the redirect target with every valid history entry.
    generate
        for (genvar gi = 0; gi < LOOP_WINDOW; gi++) begin : g_hist_cmp
            assign hist_match[gi] = hist_v_q[gi] && (hist_q[gi] == branchTarget);
        end
    endgenerate
    assign hist_hit = |hist_match;

    // A capture needs room in the FIFO, counting a slot freed by a
    // same-cycle pop. A branch in the same cycle discards the capture.
    assign capture  = (state_q == S_CAPTURE) && !branch_take &&
                      instructionmemoryDone && (!fifo_full || pop);
    assign at_last  = (pc_q == LAST_ADDR);
    assign next_seq = pc_q + COUNTSIZE'(1);

    assign push  = capture;
    assign flush = branch_take;

    // Every address actually issued is recorded in the loop history. Only
    // redirects are checked against it: a sequential advance always moves
    // to an address past every entry recorded since the last redirect.
    assign branch_issue = branch_take && !target_oob && !hist_hit;
    assign seq_issue    = capture && !at_last;
    assign issue        = branch_issue || seq_issue;
    assign issue_addr   = branch_issue ? branchTarget : next_seq;

    // ------------------------------------------------------------------
    // Fetch FSM, PC, sticky flags and loop history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_INIT;
            pc_q     <= '0;
            loop_q   <= 1'b0;
            range_q  <= 1'b0;
            halted_q <= 1'b0;
            hist_v_q <= '0;
            for (int i = 0; i < LOOP_WINDOW; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                hist_q[0]   <= issue_addr;
                hist_v_q[0] <= 1'b1;
                for (int i = 1; i < LOOP_WINDOW; i++) begin
                    hist_q[i]   <= hist_q[i-1];
                    hist_v_q[i] <= hist_v_q[i-1];
                end
            end

            case (state_q)
                S_INIT: begin
                    if (instructionmemoryDone) begin
                        state_q <= S_SETTLE;
                    end
                end

                S_SETTLE, S_CAPTURE: begin
                    if (branch_take) begin
                        // A rejected redirect leaves the PC where it was.
                        if (target_oob) begin
                            range_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else if (hist_hit) begin
                            loop_q   <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            pc_q    <= branchTarget;
                            state_q <= S_SETTLE;
                        end
                    end else if (capture) begin
                        // The last valid word is still delivered; the PC
                        // never wraps back to zero.
                        if (at_last) begin
                            range_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            pc_q    <= next_seq;
                            state_q <= S_SETTLE;
                        end
                    end else if (state_q == S_SETTLE) begin
                        state_q <= S_CAPTURE;
                    end
                end

                S_HALT: begin
                    // Terminal: only reset leaves this state. The FIFO keeps
                    // draining to decode.
                end

                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch FIFO
    // ------------------------------------------------------------------
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({pc_q, currentInstruction}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign currentCount       = pc_q;
    assign fetchValid         = !fifo_empty;
    assign fetchedPC          = fifo_head[ENTRY_W-1:INS_SIZE];
    assign fetchedInstruction = fifo_head[INS_SIZE-1:0];
    assign loopDetected       = loop_q;
    assign rangeError         = range_q;
    assign halted             = halted_q;

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A behavioural
//               instruction memory answers every address; expected {PC, word}
//               pairs are queued as stimulus is set up and compared whenever
//               decode accepts the FIFO head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  currentCount;
    logic [31:0] currentInstruction;
    logic        done;
    logic        bv;
    logic [7:0]  bt;
    logic        ready;
    logic [31:0] fetchedInstruction;
    logic [7:0]  fetchedPC;
    logic        fetchValid;
    logic        loopDetected;
    logic        rangeError;
    logic        halted;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    instruction_fetch_unit dut (
        .clk                   (clk),
        .reset                 (rst_n),
        .currentCount          (currentCount),
        .currentInstruction    (currentInstruction),
        .instructionmemoryDone (done),
        .branchValid           (bv),
        .branchTarget          (bt),
        .decodeReady           (ready),
        .fetchedInstruction    (fetchedInstruction),
        .fetchedPC             (fetchedPC),
        .fetchValid            (fetchValid),
        .loopDetected          (loopDetected),
        .rangeError            (rangeError),
        .halted                (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (a == 8'd0) return 32'h1111_1111;
        if (a == 8'd1) return 32'h2222_2222;
        return {8'hC0, a, ~a, a};
    endfunction

    assign currentInstruction = mem_word(currentCount);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: 8'(first + i), ins: mem_word(8'(first + i))});
        end
    endtask

    // Scoreboard: the head is consumed at the next rising edge whenever
    // fetchValid and decodeReady are both high.
    always @(negedge clk) begin
        if (rst_n && fetchValid && ready) begin
            chk("pop_expected_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_pc",  64'(fetchedPC), 64'(e.pc));
                chk("pop_ins", 64'(fetchedInstruction), 64'(e.ins));
            end
        end
    end

    initial begin
        int          n;
        logic [7:0]  pc_hold;
        done  = 1'b1;
        ready = 1'b0;
        bv    = 1'b0;
        bt    = 8'h00;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cc",     64'(currentCount), 64'd0);
        chk("rst_fv",     64'(fetchValid), 64'd0);
        chk("rst_fpc",    64'(fetchedPC), 64'd0);
        chk("rst_fins",   64'(fetchedInstruction), 64'd0);
        chk("rst_loop",   64'(loopDetected), 64'd0);
        chk("rst_range",  64'(rangeError), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // ---------------- first fetch latency ----------------
        push_exp(0, 16);
        rst_n = 1'b1;
        tick();
        chk("fv_edge1", 64'(fetchValid), 64'd0);
        tick();
        chk("fv_edge2", 64'(fetchValid), 64'd0);
        tick();
        chk("fv_edge3",  64'(fetchValid), 64'd1);
        chk("first_pc",  64'(fetchedPC), 64'd0);
        chk("first_ins", 64'(fetchedInstruction), 64'h1111_1111);

        // ---------------- decode stall: FIFO fills to depth ----------------
        repeat (10) tick();
        chk("stall_cc",   64'(currentCount), 64'd2);
        chk("stall_fv",   64'(fetchValid), 64'd1);
        chk("stall_head", 64'(fetchedPC), 64'd0);
        ready = 1'b1;
        repeat (6) tick();
        ready = 1'b0;
        repeat (8) tick();
        chk("fill_fv",   64'(fetchValid), 64'd1);
        chk("fill_head", 64'(fetchedPC), 64'(exp_q[0].pc));
        chk("fill_cc",   64'(currentCount), 64'(8'(exp_q[0].pc + 8'd2)));

        // ---------------- branch flushes a full FIFO ----------------
        bv = 1'b1;
        bt = 8'h40;
        exp_q.delete();
        push_exp(8'h40, 16);
        tick();
        bv = 1'b0;
        chk("br_fv", 64'(fetchValid), 64'd0);
        chk("br_cc", 64'(currentCount), 64'h40);
        ready = 1'b1;
        n = 0;
        while (!fetchValid && n < 20) begin
            tick();
            n++;
        end
        chk("br_wait_fv", 64'(fetchValid), 64'd1);
        chk("br_head_pc", 64'(fetchedPC), 64'h40);
        repeat (4) tick();

        // ---------------- tight loop: 0x10, 0x20, 0x10 ----------------
        bv = 1'b1;
        bt = 8'h10;
        tick();
        exp_q.delete();
        bt = 8'h20;
        tick();
        bt = 8'h10;
        tick();
        bv = 1'b0;
        chk("loop_flag",   64'(loopDetected), 64'd1);
        chk("loop_halted", 64'(halted), 64'd1);
        chk("loop_range",  64'(rangeError), 64'd0);
        chk("loop_cc",     64'(currentCount), 64'h20);
        chk("loop_fv",     64'(fetchValid), 64'd0);
        bv = 1'b1;
        bt = 8'h30;
        tick();
        bv = 1'b0;
        repeat (3) tick();
        chk("halt_ign_cc", 64'(currentCount), 64'h20);
        chk("halt_ign_fv", 64'(fetchValid), 64'd0);
        chk("halt_sticky", 64'(loopDetected), 64'd1);

        // ---------------- sequential run to the last address ----------------
        rst_n = 1'b0;
        #1;
        chk("rst_async_loop", 64'(loopDetected), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        push_exp(0, 256);
        rst_n = 1'b1;
        ready = 1'b1;
        n = 0;
        while (!halted && n < 1500) begin
            tick();
            n++;
        end
        chk("range_halt_reached", 64'(halted), 64'd1);
        repeat (5) tick();
        chk("range_flag",    64'(rangeError), 64'd1);
        chk("range_loop",    64'(loopDetected), 64'd0);
        chk("range_cc",      64'(currentCount), 64'd255);
        chk("range_drained", 64'(exp_q.size()), 64'd0);
        chk("range_fv",      64'(fetchValid), 64'd0);

        // ---------------- memory not done while capturing ----------------
        rst_n = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        push_exp(0, 64);
        rst_n = 1'b1;
        repeat (12) tick();
        done = 1'b0;
        pc_hold = currentCount;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_cc", 64'(currentCount), 64'(pc_hold));
        end
        chk("wait_fv", 64'(fetchValid), 64'd0);
        done = 1'b1;
        tick();
        chk("resume_cc", 64'(currentCount), 64'(8'(pc_hold + 8'd1)));
        chk("resume_fv", 64'(fetchValid), 64'd1);

        // ---------------- asynchronous reset mid-wait ----------------
        done = 1'b0;
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_cc",     64'(currentCount), 64'd0);
        chk("mid_rst_fv",     64'(fetchValid), 64'd0);
        chk("mid_rst_fpc",    64'(fetchedPC), 64'd0);
        chk("mid_rst_fins",   64'(fetchedInstruction), 64'd0);
        chk("mid_rst_halted", 64'(halted), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
